// File: rtl/stream_mux_rr.sv
// Round-robin N:1 stream mux with a registered output stage.
// Optional STREAM_MUX_RR_FORCE_SEL_EN adds force_en/force_sel channel pinning.
module stream_mux_rr #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    localparam int CW   = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]     in_valid,
    output logic [N-1:0]     in_ready,
`ifdef STREAM_MUX_RR_FORCE_SEL_EN
    input  logic             force_en,
    input  logic [CW-1:0]    force_sel,
`endif
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    out_ch,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [CW-1:0] ptr;
    logic [N-1:0]  elig;
    logic          load;
    logic          gnt_vld;
    logic [CW-1:0] gnt_idx;
    logic [CW-1:0] ptr_nxt;
    logic          ptr_hold;

`ifdef STREAM_MUX_RR_FORCE_SEL_EN
    always_comb begin
        elig     = in_valid;
        ptr_hold = 1'b0;
        if (force_en) begin
            ptr_hold = 1'b1;
            elig     = '0;
            if (int'(force_sel) < N)
                elig[force_sel] = in_valid[force_sel];
        end
    end
`else
    assign elig     = in_valid;
    assign ptr_hold = 1'b0;
`endif

    assign load = !out_valid || out_ready;

    // Search ptr, ptr+1, ... (mod N); first eligible channel wins.
    always_comb begin
        int idx;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!gnt_vld && elig[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = idx[CW-1:0];
            end
        end
    end

    assign ptr_nxt = (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;

    always_comb begin
        in_ready = '0;
        if (rst_n && load && gnt_vld)
            in_ready[gnt_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= '0;
        end else if (load) begin
            out_valid <= gnt_vld;
            if (gnt_vld) begin
                out_data <= in_data[gnt_idx*WIDTH +: WIDTH];
                out_ch   <= gnt_idx;
                if (!ptr_hold)
                    ptr <= ptr_nxt;
            end
        end
    end

endmodule

// File: doc/stream_mux_rr.md
STREAM_MUX_RR -- requirements
Module: stream_mux_rr

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the data width per channel.
REQ-002 The block SHALL have parameter N, default 4, giving the number of input channels; legal range 2..16.
REQ-003 The block SHALL derive localparam CW = $clog2(N) as the channel-index width.
REQ-004 Port clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst_n  input  1  is the asynchronous, active-low reset.
REQ-006 Port in_data  input  N*WIDTH  carries packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 Port in_valid  input  N  carries per-channel valid.
REQ-008 Port in_ready  output  N  carries per-channel ready; it SHALL be combinational.
REQ-009 Port out_data  output  WIDTH  carries registered selected data.
REQ-010 Port out_ch  output  CW  carries the registered index of the channel that sourced out_data.
REQ-011 Port out_valid  output  1  carries the registered output valid.
REQ-012 Port out_ready  input  1  carries downstream ready.

Function
REQ-013 A transfer on channel i SHALL occur when in_valid[i] and in_ready[i] are both high at a clock edge.
REQ-014 A transfer on the output SHALL occur when out_valid and out_ready are both high at a clock edge.
REQ-015 Internal load SHALL be defined as load = !out_valid || out_ready.
REQ-016 Arbitration SHALL be round-robin over valid channels, searching ptr, ptr+1, ..., ptr+N-1 (mod N) and granting the first channel with in_valid high.
REQ-017 in_ready[i] SHALL be high only when load is high and channel i is granted, so at most one bit is set.
REQ-018 On a grant with load high, the block SHALL capture out_data, out_ch and out_valid = 1 at that edge, giving 1-cycle latency.
REQ-019 On load high with no valid input, out_valid SHALL go to 0; out_data and out_ch SHALL hold.
REQ-020 On a grant, ptr SHALL become (granted index + 1) mod N, wrapping from N-1 to 0.
REQ-021 Without a grant, ptr SHALL hold.
REQ-022 While out_valid = 1 and out_ready = 0, out_data, out_ch, out_valid and ptr SHALL hold, and all in_ready SHALL be 0.
REQ-023 When an output transfer and a new grant occur at the same edge, the new word SHALL load with no bubble, sustaining 1 word/cycle.
REQ-024 in_ready SHALL NOT depend on out_valid within a cycle except through load; there SHALL be no combinational path from in_valid to out_valid.

Reset
REQ-025 While rst_n = 0, the block SHALL hold out_valid = 0, out_data = 0, out_ch = 0 and ptr = 0, and in_ready SHALL be all zero.
REQ-026 Reset assertion mid-transfer SHALL drop the held word immediately, independent of clk.
REQ-027 The first grant after reset release SHALL search from channel 0.

Configuration
REQ-028 With macro STREAM_MUX_RR_FORCE_SEL_EN defined, the block SHALL add ports force_en (input, 1) and force_sel (input, CW).
REQ-029 With the macro defined and force_en = 1, only channel force_sel SHALL be grantable, and ptr SHALL hold.
REQ-030 With the macro defined and force_sel >= N, no channel SHALL be granted.
REQ-031 With the macro defined and force_en = 0, or with the macro undefined, behaviour SHALL be pure round-robin, and the macro-undefined build SHALL NOT have the force ports.

Verification
REQ-032 Reset: drive rst_n = 0 with in_valid = 4'b1111 -> out_valid = 0, in_ready = 0, out_data = 0.
REQ-033 Round-robin: in_data = {68, 89, 67, 54}, in_valid = 4'b1111, out_ready = 1 -> out_ch sequence 0, 1, 2, 3, 0 and out_data sequence 54, 67, 89, 68, 54 on consecutive cycles.
REQ-034 Skip and wrap: in_valid = 4'b1001 from reset -> out_ch 0, 3, 0, 3; in_ready alternates 4'b0001, 4'b1000.
REQ-035 Backpressure: hold out_ready = 0 for 3 cycles after out_data = 67 -> out_data stays 67, in_ready = 0; release -> next out_ch = 2 with no word lost or duplicated.
REQ-036 Reset mid-stream: assert rst_n = 0 while out_valid = 1 at out_ch = 2, then release -> out_valid = 0, and the first grant goes to channel 0.
REQ-037 Force (macro defined): force_en = 1, force_sel = 2, all channels valid -> out_data = 89 every cycle; force_en = 0 -> round-robin resumes from the held ptr.
